// File: rtl/car_motion_if.sv
`default_nettype none
// ============================================================================
// Module      : car_motion_if
// Description : Goal/request/status bundle between the goal-floor selector and
//               the car motion controller. door_hold exists only when
//               CAR_DOOR_HOLD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface car_motion_if;
    logic [1:0] gf;
    logic       led1;
    logic       led2;
    logic       led3;
    logic [1:0] floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       clr1;
    logic       clr2;
    logic       clr3;
`ifdef CAR_DOOR_HOLD_EN
    logic       door_hold;
`endif

    // master: the car motion controller
    modport master (
`ifdef CAR_DOOR_HOLD_EN
        input  door_hold,
`endif
        input  gf, led1, led2, led3,
        output floor, moving, dir_up, door_open, clr1, clr2, clr3
    );

    // slave: goal selector / request latches
    modport slave (
`ifdef CAR_DOOR_HOLD_EN
        output door_hold,
`endif
        output gf, led1, led2, led3,
        input  floor, moving, dir_up, door_open, clr1, clr2, clr3
    );
endinterface
`default_nettype wire

// File: rtl/car_motion.sv
`default_nettype none
// ============================================================================
// Module      : car_motion
// Description : Elevator car motion controller. Steps the car one floor per
//               TRAVEL_CYCLES toward the selected goal, then opens the door for
//               DOOR_CYCLES and strobes the request clear of the current floor.
//               Optional door-hold input enabled by macro CAR_DOOR_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module car_motion #(
    parameter logic [1:0] labelF1       = 2'b00,
    parameter logic [1:0] labelF2       = 2'b01,
    parameter logic [1:0] labelF3       = 2'b10,
    parameter int         TRAVEL_CYCLES = 8,
    parameter int         DOOR_CYCLES   = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    car_motion_if.master  bus
);

    localparam int c_tcnt_w = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int c_dcnt_w = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(TRAVEL_CYCLES - 1);
    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(DOOR_CYCLES - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_move = 2'd1;
    localparam logic [1:0] c_door = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          r_idx;
    logic [1:0]          r_tgt;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic [c_dcnt_w-1:0] r_dcnt;
    logic [1:0]          r_floor;
    logic                r_moving;
    logic                r_dir_up;
    logic                r_door_open;

    logic                w_gf_valid;
    logic [1:0]          w_gf_idx;
    logic                w_gf_here;
    logic                w_led_here;
    logic [1:0]          w_next_idx;
    logic                w_hold;

    function automatic logic [1:0] idx_to_label(input logic [1:0] idx);
        case (idx)
            2'd0:    return labelF1;
            2'd1:    return labelF2;
            default: return labelF3;
        endcase
    endfunction

    always_comb begin
        w_gf_valid = 1'b1;
        w_gf_idx   = 2'd0;
        if (bus.gf == labelF1) begin
            w_gf_idx = 2'd0;
        end else if (bus.gf == labelF2) begin
            w_gf_idx = 2'd1;
        end else if (bus.gf == labelF3) begin
            w_gf_idx = 2'd2;
        end else begin
            w_gf_valid = 1'b0;
        end
    end

    always_comb begin
        w_led_here = 1'b0;
        case (r_idx)
            2'd0:    w_led_here = bus.led1;
            2'd1:    w_led_here = bus.led2;
            default: w_led_here = bus.led3;
        endcase
    end

    assign w_gf_here  = (bus.gf == r_floor);
    // Direction is fixed for the whole trip, so the next index follows dir_up
    assign w_next_idx = r_dir_up ? (r_idx + 2'd1) : (r_idx - 2'd1);

`ifdef CAR_DOOR_HOLD_EN
    assign w_hold = bus.door_hold;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_idx       <= 2'd0;
            r_tgt       <= 2'd0;
            r_tcnt      <= '0;
            r_dcnt      <= '0;
            r_floor     <= labelF1;
            r_moving    <= 1'b0;
            r_dir_up    <= 1'b0;
            r_door_open <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_gf_valid && !w_gf_here) begin
                        r_state  <= c_move;
                        r_tgt    <= w_gf_idx;
                        r_dir_up <= (w_gf_idx > r_idx);
                        r_moving <= 1'b1;
                        r_tcnt   <= '0;
                    end else if (w_gf_here && w_led_here) begin
                        r_state     <= c_door;
                        r_door_open <= 1'b1;
                        r_dcnt      <= '0;
                    end
                end
                c_move: begin
                    if (r_tcnt == c_tcnt_last) begin
                        r_tcnt  <= '0;
                        r_idx   <= w_next_idx;
                        r_floor <= idx_to_label(w_next_idx);
                        // Arrival: floor update, motion stop and door open share one edge
                        if (w_next_idx == r_tgt) begin
                            r_state     <= c_door;
                            r_moving    <= 1'b0;
                            r_door_open <= 1'b1;
                            r_dcnt      <= '0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                c_door: begin
                    if (w_hold) begin
                        r_dcnt <= '0;
                    end else if (r_dcnt == c_dcnt_last) begin
                        r_state     <= c_idle;
                        r_door_open <= 1'b0;
                        r_dcnt      <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.floor     = r_floor;
    assign bus.moving    = r_moving;
    assign bus.dir_up    = r_dir_up;
    assign bus.door_open = r_door_open;
    assign bus.clr1      = (r_state == c_door) && (r_floor == labelF1) && bus.led1;
    assign bus.clr2      = (r_state == c_door) && (r_floor == labelF2) && bus.led2;
    assign bus.clr3      = (r_state == c_door) && (r_floor == labelF3) && bus.led3;

endmodule
`default_nettype wire

// File: tb/tb_car_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_motion
// Description : Directed and randomized bench for car_motion against a
//               trip-level reference model (TRAVEL_CYCLES=4, DOOR_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_motion;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: floor index, trip target, and edges remaining in the
    // current leg (travel) or door period.
    int   m_mode;  // 0 idle, 1 travelling, 2 door open
    int   m_pos;
    int   m_tgt;
    int   m_left;
    logic m_up;

    car_motion_if bus ();

    car_motion #(
        .labelF1       (2'b00),
        .labelF2       (2'b01),
        .labelF3       (2'b10),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic led_at(input int idx);
        case (idx)
            0:       return bus.led1;
            1:       return bus.led2;
            default: return bus.led3;
        endcase
    endfunction

    task automatic model_edge();
        logic hold;
`ifdef CAR_DOOR_HOLD_EN
        hold = bus.door_hold;
`else
        hold = 1'b0;
`endif
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_tgt = 0; m_left = 0; m_up = 1'b0;
        end else if (m_mode == 0) begin
            if (bus.gf != 2'b11 && int'(bus.gf) != m_pos) begin
                m_tgt  = int'(bus.gf);
                m_up   = (m_tgt > m_pos);
                m_mode = 1;
                m_left = TRAVEL;
            end else if (int'(bus.gf) == m_pos && led_at(m_pos)) begin
                m_mode = 2;
                m_left = DOOR;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_pos = m_up ? m_pos + 1 : m_pos - 1;
                if (m_pos == m_tgt) begin
                    m_mode = 2;
                    m_left = DOOR;
                end else begin
                    m_left = TRAVEL;
                end
            end
        end else begin
            if (hold) begin
                m_left = DOOR;
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
    endtask

    function automatic logic [7:0] observed();
        return {bus.floor, bus.moving, bus.dir_up, bus.door_open,
                bus.clr1, bus.clr2, bus.clr3};
    endfunction

    function automatic logic [7:0] expected();
        logic dr;
        dr = (m_mode == 2);
        return {2'(m_pos), m_mode == 1, m_up, dr,
                dr && m_pos == 0 && bus.led1,
                dr && m_pos == 1 && bus.led2,
                dr && m_pos == 2 && bus.led3};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", observed(), expected());
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.gf   = 2'b10;
        bus.led1 = 1'b0;
        bus.led2 = 1'b0;
        bus.led3 = 1'b0;
`ifdef CAR_DOOR_HOLD_EN
        bus.door_hold = 1'b0;
`endif
        m_mode = 0; m_pos = 0; m_tgt = 0; m_left = 0; m_up = 1'b0;

        // Reset held with a pending goal
        ticks(2);
        chk("reset", observed(), 8'h00);

        // Up two floors
        rst_n    = 1'b1;
        bus.led3 = 1'b1;
        tick();
        chk("depart_up", observed(), 8'h30);
        ticks(3);
        tick();
        chk("up_floor2", observed(), 8'h70);
        ticks(3);
        tick();
        chk("up_arrive", observed(), 8'h99);
        bus.led3 = 1'b0;
        ticks(2);
        chk("door_hold3", {7'b0, bus.door_open}, 8'h01);
        tick();
        chk("door_close", observed(), 8'h90);

        // Down one floor, goal changed mid-trip is ignored
        bus.gf   = 2'b01;
        bus.led2 = 1'b1;
        tick();
        chk("depart_dn", observed(), 8'hA0);
        bus.gf = 2'b00;
        ticks(3);
        tick();
        chk("dn_arrive", observed(), 8'h4A);

        // Continue to floor 1, then same-floor request reopens the door
        bus.led2 = 1'b0;
        bus.led1 = 1'b1;
        ticks(14);
        bus.led1 = 1'b0;
        ticks(6);
        chk("idle_nolED", observed(), 8'h00);
        bus.gf = 2'b11;
        ticks(5);
        chk("idle_gf11", observed(), 8'h00);

        // Same-floor request gives door with no motion
        bus.gf   = 2'b00;
        bus.led1 = 1'b1;
        tick();
        chk("same_floor", observed(), 8'h0C);
`ifdef CAR_DOOR_HOLD_EN
        bus.door_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_open", {7'b0, bus.door_open}, 8'h01);
        end
        bus.door_hold = 1'b0;
        bus.led1      = 1'b0;
        ticks(2);
        chk("hold_tail", {7'b0, bus.door_open}, 8'h01);
        tick();
        chk("hold_close", {7'b0, bus.door_open}, 8'h00);
`else
        bus.led1 = 1'b0;
        ticks(3);
        chk("same_close", observed(), 8'h00);
`endif

        // Reset in the middle of a trip
        bus.gf = 2'b10;
        ticks(6);
        rst_n = 1'b0;
        tick();
        chk("reset_move", observed(), 8'h00);
        rst_n  = 1'b1;
        bus.gf = 2'b11;
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) bus.gf = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) {bus.led1, bus.led2, bus.led3} = 3'($urandom);
            rst_n = ($urandom_range(0, 149) != 0);
`ifdef CAR_DOOR_HOLD_EN
            bus.door_hold = ($urandom_range(0, 5) == 0);
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/car_motion.md
# car_motion

Elevator car motion controller: the consumer of the goal-floor selector's output and the producer of its `floor` and `moving` inputs. It takes the selected goal floor (`gf`) and the per-floor request LEDs. It steps the car one floor at a time using a travel timer, then holds the door open for a fixed time. While the door is open it issues clear strobes for the request of the current floor. This closes the loop between the goal selector and the request latches.

## Interface
- `labelF1`, default 2'b00, encoding of floor 1 (lowest).
- `labelF2`, default 2'b01, encoding of floor 2.
- `labelF3`, default 2'b10, encoding of floor 3 (highest).
- `TRAVEL_CYCLES`, default 8, clock cycles spent between adjacent floors; must be ≥1.
- `DOOR_CYCLES`, default 4, clock cycles the door stays open; must be ≥1.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `gf`  in  2  goal floor from the goal selector; any value not equal to a label is ignored.
- `led1`, `led2`, `led3`  in  1 each  pending request at floor 1/2/3.
- `floor`  out  2  current floor label, registered.
- `moving`  out  1  car is travelling, registered.
- `dir_up`  out  1  direction of the current/last travel, registered.
- `door_open`  out  1  door open, registered.
- `clr1`, `clr2`, `clr3`  out  1 each  request-clear strobe for floor 1/2/3.
- `door_hold`  in  1  present only with `CAR_DOOR_HOLD_EN` (see Configuration).

## Operation
- Floor index: labelF1=0, labelF2=1, labelF3=2. Stepping up means index+1; stepping down means index−1. The index never leaves the range 0..2.
- States:
  - IDLE
  - MOVE: target index latched on entry; `gf` is ignored while in MOVE.
  - DOOR
- IDLE transitions:
  - If `gf` is a valid label and differs from `floor`: go to MOVE. Latch the target, set `dir_up` = (target > current), set `moving`=1, clear the travel counter.
  - Else if `gf`==`floor` and the LED of the current floor is 1: go to DOOR and set `door_open`=1.
  - Else stay in IDLE.
- MOVE:
  - The travel counter increments every cycle.
  - When the counter reaches TRAVEL_CYCLES−1, `floor` steps one index toward the target and the counter clears.
  - If the new floor equals the target: on the same edge go to DOOR, with `moving`=0 and `door_open`=1.
  - Otherwise remain in MOVE.
- DOOR:
  - The door counter counts DOOR_CYCLES cycles.
  - At the end of the count go to IDLE with `door_open`=0.
- Clear strobes: `clrN` = (state==DOOR) & (`floor`==labelFN) & `ledN`. This is combinational from registered state plus the LED input. It reasserts for a new press made while the door is open.
- `clrN` is never asserted outside DOOR.
- A `floor` value that is not one of the three labels cannot occur.

## Timing
- Reset values: `floor`=labelF1, `moving`=0, `dir_up`=0, `door_open`=0, all `clrN`=0, state IDLE, counters 0.
- Reset mid-operation: on the next edge everything returns to the reset values. No partial step is retained.
- Departure latency: a valid `gf`≠`floor` sampled at edge N gives `moving`=1 after edge N.
- Travel:
  - Each floor change occurs TRAVEL_CYCLES edges after the previous change, or after entry to MOVE.
  - A two-floor trip arrives 2·TRAVEL_CYCLES edges after departure.
- Arrival edge: `floor` update, `moving`→0 and `door_open`→1 happen on the same edge. `clrN` is high in the following cycle if `ledN`=1.
- Door: `door_open` is high for exactly DOOR_CYCLES cycles. The IDLE decision is made in the cycle after `door_open` falls.
- `gf`=2'b11, or `gf`==`floor` with no LED set, keeps the block in IDLE indefinitely.

## Configuration
- `CAR_DOOR_HOLD_EN` defined:
  - Adds the `door_hold` input.
  - While in DOOR with `door_hold`=1, the door counter is held at 0, so the door stays open.
  - Counting resumes from 0 after release, giving a full DOOR_CYCLES after release.
- Undefined: the port does not exist and the door always closes after DOOR_CYCLES.

## Test plan
Parameters for all scenarios: TRAVEL_CYCLES=4, DOOR_CYCLES=3.

- Reset:
  - Assert `rst_n`=0 for 2 cycles with `gf`=2'b10.
  - Required: `floor`=00, `moving`=0, `door_open`=0, `clr*`=0. After release, `moving`=1 on the first edge.
- Up two floors:
  - From IDLE at 00, drive `gf`=10 and `led3`=1.
  - Required: `floor`=01 after 4 edges and `floor`=10 after 8 edges. On that same edge `moving`=0, `door_open`=1 and `dir_up`=1; `clr3`=1 next cycle.
  - `door_open` stays high for 3 cycles, then IDLE.
- Down one floor:
  - From 10, drive `gf`=01 and `led2`=1.
  - Required: `dir_up`=0 and `floor`=01 after 4 edges; `clr2` asserts, while `clr1` and `clr3` stay 0.
- Same-floor request:
  - At 00, drive `gf`=00 and `led1`=1.
  - Required: `door_open`=1 after 1 edge with no `moving` pulse; `clr1`=1.
  - With `led1`=0 and `gf`=00 the block stays IDLE.
- Ignored inputs:
  - `gf`=11 while IDLE: no motion.
  - Changing `gf` mid-MOVE: the original target is still reached.
  - Reset during MOVE: `floor` returns to 00 on the next edge.
- `CAR_DOOR_HOLD_EN` defined: hold `door_hold`=1 for 5 cycles during DOOR.
  - Required: `door_open` stays high for all 5 cycles plus 3 cycles after release.
